// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder.
//   master : operand producer and result consumer (drives in_valid, a, b,
//            cin, abort, out_ready; observes in_ready, out_valid, sum, cout)
//   slave  : the serial adder itself
// Two valid/ready channels share this bundle: operands in, {cout,sum} out.
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, abort, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, abort, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop.
// Operands are captured on an in_valid/in_ready accept, added LSB-first one
// bit per clock, and {cout,sum} is presented on an out_valid/out_ready
// channel. abort cancels the operation in flight (ADD or DONE).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: in_valid/in_ready/a/b/cin/abort,
//          out_valid/out_ready/sum/cout
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum;
   logic             fa_carry;
   logic             last_bit;
   logic             accept;

   // Full-adder cell built from two half adders (same structure as FAusingHA:
   // a,b,c -> sum,carry). Returns {carry,sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b,
                                           input logic c);
      logic s1, c1, s2, c2;
      s1 = a ^ b;
      c1 = a & b;
      s2 = s1 ^ c;
      c2 = s1 & c;
      return {c1 | c2, s2};
   endfunction

   assign {fa_carry, fa_sum} = full_add(a_sr[0], b_sr[0], carry);

   // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at acc[0].
   always_comb begin
      acc_nxt            = acc >> 1;
      acc_nxt[WIDTH-1]   = fa_sum;
   end

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign accept   = bus.in_valid & (state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // abort is ignored here; an accept on the same edge proceeds
               if (accept) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.b;
                  carry <= bus.cin;
                  cnt   <= '0;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               acc   <= acc_nxt;
               carry <= fa_carry;
               cnt   <= cnt + CNT_W'(1);
               // abort wins over the final-bit commit: result registers untouched
               if (bus.abort) begin
                  state <= S_IDLE;
               end else if (last_bit) begin
                  sum_q  <= acc_nxt;
                  cout_q <= fa_carry;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.abort || bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table, hand-written handshake/abort/
// reset sequences, and random operations on WIDTH=8 and WIDTH=1 instances
// checked against plain-arithmetic expectations.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) if8();
   serial_adder_if #(.WIDTH(1)) if1();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] esum;
      logic       ecout;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the WIDTH=8 instance. Called 1ns after an edge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input int stall,
                      output logic [7:0] s, output logic c);
      int lat;
      check("op8 in_ready before accept", if8.in_ready, 1);
      if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1;
      step();
      if8.in_valid = 1'b0;
      // operands change after the accept; they must not matter
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
      lat = 0;
      while (!if8.out_valid && lat < 12) begin
         step();
         lat++;
      end
      check("op8 latency", lat, 8);
      s = if8.sum;
      c = if8.cout;
      for (int i = 0; i < stall; i++) begin
         if8.in_valid = 1'($urandom);
         if8.a = 8'($urandom); if8.b = 8'($urandom);
         step();
         check("stall out_valid", if8.out_valid, 1);
         check("stall in_ready", if8.in_ready, 0);
         check("stall sum", {if8.cout, if8.sum}, {c, s});
      end
      if8.in_valid = 1'b0;
      if8.out_ready = 1'b1;
      step();
      if8.out_ready = 1'b0;
      check("op8 out_valid after take", if8.out_valid, 0);
   endtask

   task automatic op1(input logic a, input logic b, input logic cin,
                      input int stall, output logic s, output logic c);
      int lat;
      check("op1 in_ready before accept", if1.in_ready, 1);
      if1.a = a; if1.b = b; if1.cin = cin; if1.in_valid = 1'b1;
      step();
      if1.in_valid = 1'b0;
      lat = 0;
      while (!if1.out_valid && lat < 6) begin
         step();
         lat++;
      end
      check("op1 latency", lat, 1);
      s = if1.sum[0];
      c = if1.cout;
      repeat (stall) step();
      check("op1 held after stall", {if1.out_valid, if1.cout, if1.sum[0]}, {1'b1, c, s});
      if1.out_ready = 1'b1;
      step();
      if1.out_ready = 1'b0;
   endtask

   initial begin
      vec_t       vecs[5];
      logic [7:0] s;
      logic       c;
      logic       s1, c1;
      logic [8:0] ref9;
      logic [1:0] ref2;

      vecs[0] = '{a: 8'h3C, b: 8'h5A, cin: 1'b0, esum: 8'h96, ecout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, esum: 8'h00, ecout: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, esum: 8'hFF, ecout: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, esum: 8'h01, ecout: 1'b0};
      vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, esum: 8'h80, ecout: 1'b0};

      if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.abort = 0; if8.out_ready = 0;
      if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.cin = 0; if1.abort = 0; if1.out_ready = 0;

      // reset state
      repeat (3) step();
      check("reset in_ready", if8.in_ready, 1);
      check("reset out_valid", if8.out_valid, 0);
      check("reset sum/cout", {if8.cout, if8.sum}, 0);
      check("reset w1 in_ready/out_valid", {if1.in_ready, if1.out_valid}, 2'b10);
      rst_n = 1'b1;
      step();

      // directed table
      foreach (vecs[i]) begin
         op8(vecs[i].a, vecs[i].b, vecs[i].cin, 0, s, c);
         check("table result", {c, s}, {vecs[i].ecout, vecs[i].esum});
      end

      // long stall in DONE with in_valid pulses ignored
      op8(8'h3C, 8'h5A, 1'b0, 5, s, c);
      check("stall result", {c, s}, 9'h096);
      repeat (2) begin
         step();
         check("no spurious op after stall", {if8.in_ready, if8.out_valid}, 2'b10);
      end

      // abort in the 3rd ADD cycle
      if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b0; if8.in_valid = 1'b1;
      step();                       // accept
      if8.in_valid = 1'b0;
      step();
      step();
      if8.abort = 1'b1;
      step();
      if8.abort = 1'b0;
      check("abort -> idle", {if8.in_ready, if8.out_valid}, 2'b10);
      step();
      check("abort keeps result", {if8.out_valid, if8.cout, if8.sum}, {1'b0, 9'h096});
      op8(8'h12, 8'h34, 1'b1, 1, s, c);
      check("op after abort", {c, s}, 9'h047);

      // abort on the final ADD edge: result registers must not update
      if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b1; if8.in_valid = 1'b1;
      step();
      if8.in_valid = 1'b0;
      repeat (7) step();
      if8.abort = 1'b1;
      step();
      if8.abort = 1'b0;
      check("final-edge abort", {if8.in_ready, if8.out_valid, if8.cout, if8.sum},
            {2'b10, 9'h047});

      // abort in DONE together with out_ready, then abort in IDLE with accept
      if8.a = 8'h01; if8.b = 8'h02; if8.cin = 1'b0; if8.in_valid = 1'b1;
      step();
      if8.in_valid = 1'b0;
      repeat (8) step();
      check("done reached", {if8.out_valid, if8.cout, if8.sum}, {1'b1, 9'h003});
      if8.abort = 1'b1; if8.out_ready = 1'b1;
      step();
      if8.out_ready = 1'b0;
      check("done abort -> idle", {if8.in_ready, if8.out_valid}, 2'b10);
      if8.a = 8'h40; if8.b = 8'h41; if8.in_valid = 1'b1;  // abort still high
      step();
      if8.abort = 1'b0; if8.in_valid = 1'b0;
      check("idle abort ignored", if8.in_ready, 0);
      repeat (8) step();
      check("idle abort op result", {if8.out_valid, if8.cout, if8.sum}, {1'b1, 9'h081});
      if8.out_ready = 1'b1;
      step();
      if8.out_ready = 1'b0;

      // asynchronous reset mid-ADD
      if8.a = 8'h0F; if8.b = 8'h0F; if8.cin = 1'b0; if8.in_valid = 1'b1;
      step();
      if8.in_valid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", {if8.in_ready, if8.out_valid, if8.cout, if8.sum},
            {2'b10, 9'h000});
      step();
      rst_n = 1'b1;
      step();
      check("post-reset idle", {if8.in_ready, if8.out_valid}, 2'b10);
      op8(8'h80, 8'h80, 1'b0, 0, s, c);
      check("post-reset op", {c, s}, 9'h100);

      // random WIDTH=8
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         ref9 = 9'(ra) + 9'(rb) + 9'(rc);
         op8(ra, rb, rc, $urandom_range(0, 3), s, c);
         check("random w8", {c, s}, ref9);
         repeat ($urandom_range(0, 1)) step();
      end

      // random WIDTH=1
      for (int i = 0; i < 1000; i++) begin
         logic ra, rb, rc;
         ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
         ref2 = 2'(ra) + 2'(rb) + 2'(rc);
         op1(ra, rb, rc, $urandom_range(0, 3), s1, c1);
         check("random w1", {c1, s1}, ref2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
